// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the long-op decode also used by the Hazard unit. MDU_MADD_EN enables MADD/MSUB.
package mdu_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MFHI  = 4'd7;
  localparam md_op_t MD_MFLO  = 4'd8;
  localparam md_op_t MD_MADD  = 4'd9;
  localparam md_op_t MD_MADDU = 4'd10;
  localparam md_op_t MD_MSUB  = 4'd11;
  localparam md_op_t MD_MSUBU = 4'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for multiple cycles and therefore raise busy.
  function automatic logic is_md_long(input md_op_t op);
    logic long_op;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
    return long_op;
  endfunction

  function automatic logic is_md_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage side bus of the multiply/divide unit: request, operands and HI/LO results.
interface mult_div_unit_if;
  import mdu_pkg::*;

  logic        start;
  md_op_t      op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result_sel;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, hi, lo, result_sel
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, hi, lo, result_sel
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO arithmetic for mult_div_unit; o_we=0 means leave HI/LO untouched.
// With MDU_MADD_EN the current HI/LO is taken as the accumulate base.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_t      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
`ifdef MDU_MADD_EN
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
`endif
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_we
);

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [31:0]        w_den_s;
  logic [31:0]        w_den_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;

  assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  // Divisors are forced to 1 in the zero/overflow cases so the dividers never
  // see an undefined operation; those results are replaced below anyway.
  assign w_div_zero = (i_rt == 32'd0);
  assign w_div_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);
  assign w_den_s    = (w_div_zero || w_div_ovf) ? 32'd1 : i_rt;
  assign w_den_u    = w_div_zero ? 32'd1 : i_rt;

  assign w_quot_s = $signed(i_rs) / $signed(w_den_s);
  assign w_rem_s  = $signed(i_rs) % $signed(w_den_s);
  assign w_quot_u = i_rs / w_den_u;
  assign w_rem_u  = i_rs % w_den_u;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_hi = '0;
    o_lo = '0;
    o_we = 1'b0;
    case (i_op)
      MD_MULT: begin
        {o_hi, o_lo} = w_prod_s;
        o_we         = 1'b1;
      end
      MD_MULTU: begin
        {o_hi, o_lo} = w_prod_u;
        o_we         = 1'b1;
      end
      MD_DIV: begin
        if (w_div_ovf) begin
          o_lo = 32'h8000_0000;
          o_hi = 32'd0;
          o_we = 1'b1;
        end else if (!w_div_zero) begin
          o_lo = w_quot_s;
          o_hi = w_rem_s;
          o_we = 1'b1;
        end
      end
      MD_DIVU: begin
        if (!w_div_zero) begin
          o_lo = w_quot_u;
          o_hi = w_rem_u;
          o_we = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {o_hi, o_lo} = w_acc + w_prod_s;
        o_we         = 1'b1;
      end
      MD_MADDU: begin
        {o_hi, o_lo} = w_acc + w_prod_u;
        o_we         = 1'b1;
      end
      MD_MSUB: begin
        {o_hi, o_lo} = w_acc - w_prod_s;
        o_we         = 1'b1;
      end
      MD_MSUBU: begin
        {o_hi, o_lo} = w_acc - w_prod_u;
        o_we         = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit beside the E stage: FSM, latency counter,
// pending result and HI/LO registers. MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  cnt_t        r_count;
  cnt_t        w_count_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;

  logic        w_load;
  logic        w_commit;
  logic        w_mthi;
  logic        w_mtlo;
  logic [31:0] w_arith_hi;
  logic [31:0] w_arith_lo;
  logic        w_arith_we;

  mdu_arith u_arith (
    .i_op (bus.op),
    .i_rs (bus.rs_val),
    .i_rt (bus.rt_val),
`ifdef MDU_MADD_EN
    .i_hi (r_hi),
    .i_lo (r_lo),
`endif
    .o_hi (w_arith_hi),
    .o_lo (w_arith_lo),
    .o_we (w_arith_we)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (is_md_long(bus.op)) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
            w_count_nxt = is_md_div(bus.op) ? cnt_t'(DIV_CYCLES) : cnt_t'(MUL_CYCLES);
          end else begin
            w_mthi = (bus.op == MD_MTHI);
            w_mtlo = (bus.op == MD_MTLO);
          end
        end
      end
      S_RUN: begin
        // Requests arriving here are protocol violations and are dropped.
        if (r_count <= cnt_t'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count - cnt_t'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_load) begin
        r_pend_hi <= w_arith_hi;
        r_pend_lo <= w_arith_lo;
        r_pend_we <= w_arith_we;
      end
      if (w_commit) begin
        if (r_pend_we) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else begin
        if (w_mthi) r_hi <= bus.rs_val;
        if (w_mtlo) r_lo <= bus.rs_val;
      end
    end
  end

  // MFHI/MFLO read committed registers only; the Hazard unit guarantees idle.
  always_comb begin
    bus.result_sel = '0;
    case (bus.op)
      MD_MFHI: bus.result_sel = r_hi;
      MD_MFLO: bus.result_sel = r_lo;
      default: ;
    endcase
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && (r_state == S_RUN)) begin
      assert (!bus.start)
        else $warning("mult_div_unit: start while busy, request ignored");
    end
  end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy length queued at issue,
// compared when busy drops. Build with MDU_MADD_EN to exercise the accumulate ops.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on native int/longint types.
  function automatic logic [63:0] model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    int          sa = int'(a);
    int          sb_ = int'(b);
    longint      ps = longint'(sa) * longint'(sb_);
    logic [63:0] pu = 64'(a) * 64'(b);
    logic [63:0] base = {hi, lo};
    case (op)
      MD_MULT:  return ps;
      MD_MULTU: return pu;
      MD_DIV: begin
        if (b == 32'd0) return base;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb_), 32'(sa / sb_)};
      end
      MD_DIVU: begin
        if (b == 32'd0) return base;
        return {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  return base + 64'(ps);
      MD_MADDU: return base + pu;
      MD_MSUB:  return base - 64'(ps);
      MD_MSUBU: return base - pu;
`endif
      default:  return base;
    endcase
  endfunction

  task automatic idle();
    bus.start  = 1'b0;
    bus.op     = MD_NONE;
    bus.rs_val = '0;
    bus.rt_val = '0;
  endtask

  task automatic run_long(input string tag, input md_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude);
    exp_t e;
    int   n;
    @(negedge clk);
    e.tag         = tag;
    {e.hi, e.lo}  = model(op, a, b, m_hi, m_lo);
    e.cycles      = is_md_div(op) ? DIV_N : MUL_N;
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    idle();
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (intrude && n == 2) begin
        bus.start  = 1'b1;
        bus.op     = MD_DIVU;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd3;
      end else begin
        idle();
      end
      @(negedge clk);
    end
    idle();
    e = sb.pop_front();
    check({e.tag, "_cycles"}, 64'(n), 64'(e.cycles));
    check({e.tag, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
    check({e.tag, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
  endtask

  task automatic mt(input string tag, input md_op_t op, input logic [31:0] v);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = v;
    @(negedge clk);
    idle();
    if (op == MD_MTHI) m_hi = v;
    else               m_lo = v;
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;

    run_long("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    run_long("multu",     MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_long("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_long("divu",      MD_DIVU,  32'd7,         32'd2, 1'b0);
    run_long("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    mt("mthi_11", MD_MTHI, 32'h11);
    mt("mtlo_22", MD_MTLO, 32'h22);
    run_long("div_zero",  MD_DIV,   32'd5,         32'd0, 1'b0);
    run_long("divu_zero", MD_DIVU,  32'd9,         32'd0, 1'b0);

    // MTLO followed immediately by MFLO, then MFHI.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTLO; bus.rs_val = 32'h1234;
    @(negedge clk);
    m_lo = 32'h1234;
    bus.start = 1'b1; bus.op = MD_MFLO; bus.rs_val = '0;
    #1;
    check("mflo_b2b", {32'd0, bus.result_sel}, {32'd0, m_lo});
    bus.op = MD_MFHI;
    #1;
    check("mfhi", {32'd0, bus.result_sel}, {32'd0, m_hi});
    @(negedge clk);
    idle();
    check("mf_busy", {63'd0, bus.busy}, 64'd0);

    run_long("intrude", MD_MULT, 32'd6, 32'd7, 1'b1);

    // Reset in the middle of a divide discards it.
    mt("mthi_55", MD_MTHI, 32'h55);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    check("rst_mid_pre_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MFHI;
    #1;
    check("rst_mfhi", {32'd0, bus.result_sel}, 64'd0);
    @(negedge clk);
    idle();
    repeat (DIV_N + 2) @(negedge clk);
    check("rst_after_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_after_hilo", {bus.hi, bus.lo}, 64'd0);

    mt("mthi_0", MD_MTHI, 32'd0);
    mt("mtlo_5", MD_MTLO, 32'd5);
`ifdef MDU_MADD_EN
    run_long("madd", MD_MADD, 32'd2, 32'd3, 1'b0);
    mt("mthi_c", MD_MTHI, 32'd0);
    mt("mtlo_c", MD_MTLO, 32'd0);
    run_long("msubu", MD_MSUBU, 32'd1, 32'd1, 1'b0);
    run_long("msub",  MD_MSUB,  32'hFFFF_FFFF, 32'd4, 1'b0);
    run_long("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'd2, 1'b0);
`else
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MADD; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    @(negedge clk);
    idle();
    check("madd_off_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    check("madd_off_busy2", {63'd0, bus.busy}, 64'd0);
    check("madd_off_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
`endif

    for (int i = 0; i < 8; i++) begin
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      case (i % 4)
        0:       op = MD_MULT;
        1:       op = MD_MULTU;
        2:       op = MD_DIV;
        default: op = MD_DIVU;
      endcase
      a = $urandom();
      b = (i % 2 == 0) ? $urandom() : $urandom_range(1, 1000);
      run_long($sformatf("rand%0d", i), op, a, b, 1'b0);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit beside the Execution stage of the 5-stage pipeline.
- Takes rs/rt operands already forwarded in E, runs MULT/MULTU/DIV/DIVU for a fixed latency, and holds results in the HI/LO registers.
- Drives `busy` to the Hazard unit, which stalls any multiply/divide-class instruction in D (including MFHI/MFLO) while `busy` or `start` is high.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (min 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (min 1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is a multiply/divide-class op; qualifies op.
- op  input  4  operation code from the shared package.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  long operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- result_sel  output  32  HI for MFHI, LO for MFLO; combinational on op, into E-stage result mux.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, count=0, state=IDLE. Asserting reset mid-operation aborts the operation; pending results are discarded.
- States: IDLE, RUN.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU:
  - Compute the result into internal pending_hi/pending_lo at that edge.
  - Load count with MUL_CYCLES or DIV_CYCLES, go to RUN.
  - busy=1 from the next cycle.
- RUN: count decrements each cycle. When count reaches 1:
  - that edge commits pending to hi/lo and returns to IDLE;
  - busy=0 in the following cycle.
  - An op issued at edge t therefore shows busy for exactly N cycles, and hi/lo update at edge t+N.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned product.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
- DIVU: unsigned quotient and remainder.
- Divide by zero: busy runs for the full DIV_CYCLES; hi/lo are left unchanged.
- 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE: hi or lo = rs_val at the next edge; busy stays 0.
- MFHI/MFLO: no state change. result_sel reflects committed hi/lo; no internal bypass.
- start=1 while in RUN is a protocol violation (Hazard prevents it). The request is ignored; a simulation-only assertion flags it.
- No flush input: MIPS never cancels an issued MD op.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op additionally decodes MADD/MADDU/MSUB/MSUBU.
  - {hi,lo} ± signed or unsigned product, 64-bit wrap, using MUL_CYCLES latency.
  - The accumulate base is the hi/lo value captured at start.
- Undefined: these codes are treated as no-ops (no state change, busy=0).

Decomposition:
- Package mdu_pkg holds:
  - op localparams: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO, and MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU;
  - state encodings;
  - function is_md_long(op), shared with Hazard.
- One sub-module, mdu_arith: purely combinational. Takes op and operands (plus hi/lo when MDU_MADD_EN) and produces the 64-bit pending result, including the divide-by-zero and overflow rules.
- The top holds the FSM, counter and HI/LO registers.

Test Plan:
- Reset: reset=0 mid-RUN of a DIV → busy=0 and hi=lo=0 immediately; after release, a stray MFHI reads 0.
- MULT latency: rs=0xFFFFFFFE (-2), rt=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV signs: rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIVU rs=7, rt=2 → lo=3, hi=1.
- Boundaries:
  - DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
  - Divide by zero with hi=0x11, lo=0x22 preset via MTHI/MTLO → busy for 10 cycles, then hi/lo unchanged.
- Back-to-back: MTLO 0x1234 then MFLO next cycle → result_sel=0x1234. Start asserted during RUN → ignored; assertion fires; in-flight result unaffected.
- MDU_MADD_EN: hi:lo=0:5, MADD rs=2, rt=3 → lo=11, hi=0. MSUBU from 0:0 with rs=rt=1 → hi=lo=0xFFFFFFFF. Without the macro, the same code → no change.
